// File: rtl/dmem_pkg.sv
// Shared definitions for the Y86 data-memory responder: FSM states, stat codes
// used alongside rsp_error by the memory stage, and word-size constants.
package dmem_pkg;

  localparam int WORD_BYTES = 8;
  localparam int DATA_W     = WORD_BYTES * 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  typedef enum logic [2:0] {
    AOK = 3'd1,
    HLT = 3'd2,
    ADR = 3'd3,
    INS = 3'd4
  } stat_t;

  // Memory-stage status contributed by a data access.
  function automatic stat_t mem_stat(input logic err);
    return err ? ADR : AOK;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port DEPTH_WORDS x 64 storage with write enable and a
// registered read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 8192,
  parameter int ADDR_W      = 13
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
  logic [DATA_W-1:0] r_rdata;

  // NOTE: storage and its read register have no reset; clearing a RAM-sized
  // array on reset would prevent it from mapping onto a memory macro.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory responder with one outstanding request and fixed
// latency. Define DMEM_ALIGN_CHECK_EN to flag addresses with addr[2:0] != 0.
module dmem_responder #(
  parameter int DEPTH_WORDS = 8192,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_error
);

  import dmem_pkg::*;

  localparam int          ADDR_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [63:0] ADDR_LIMIT = 64'(DEPTH_WORDS) * 64'(WORD_BYTES);

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_write;
  logic              r_err;
  logic [ADDR_W-1:0] r_idx;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic              r_rsp_error;
  logic              r_rd_ok;

  logic              w_accept;
  logic              w_misalign;
  logic              w_req_err;
  logic [ADDR_W-1:0] w_req_idx;
  logic              w_enter_resp;
  logic              w_cur_write;
  logic              w_cur_err;
  logic              w_arr_we;
  logic              w_arr_re;
  logic [ADDR_W-1:0] w_arr_addr;
  logic [63:0]       w_arr_rdata;

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_misalign = |req_addr[2:0];
`else
  assign w_misalign = 1'b0;
`endif

  // Full-width compare so high address bits can never alias into the array.
  assign w_req_err = (req_addr >= ADDR_LIMIT) || w_misalign;
  assign w_req_idx = req_addr[ADDR_W+2:3];
  assign w_accept  = req_valid && r_req_ready;

  // In IDLE the request being accepted is still on the bus; later it is latched.
  assign w_cur_write  = (r_state == IDLE) ? req_write : r_write;
  assign w_cur_err    = (r_state == IDLE) ? w_req_err : r_err;
  assign w_enter_resp = ((r_state == IDLE) && w_accept && (LATENCY == 1)) ||
                        ((r_state == BUSY) && (r_cnt == 4'd0));

  assign w_arr_we   = (r_state == IDLE) && w_accept && req_write && !w_req_err;
  assign w_arr_re   = w_enter_resp && !w_cur_write && !w_cur_err;
  assign w_arr_addr = (r_state == IDLE) ? w_req_idx : r_idx;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_arr_we),
    .i_re    (w_arr_re),
    .i_addr  (w_arr_addr),
    .i_wdata (req_wdata),
    .o_rdata (w_arr_rdata)
  );

  // NOTE: every register here uses <= so all of them sample pre-edge values;
  // a blocking assignment would leak a new value into later statements.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_write     <= 1'b0;
      r_err       <= 1'b0;
      r_idx       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
      r_rd_ok     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_write     <= req_write;
            r_err       <= w_req_err;
            r_idx       <= w_req_idx;
            r_req_ready <= 1'b0;
            if (LATENCY == 1) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_error <= w_req_err;
              r_rd_ok     <= !req_write && !w_req_err;
            end else begin
              r_state <= BUSY;
              r_cnt   <= 4'(LATENCY - 2);
            end
          end
        end
        BUSY: begin
          if (r_cnt == 4'd0) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_error <= r_err;
            r_rd_ok     <= !r_write && !r_err;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            r_rd_ok     <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_error = r_rsp_error;
  assign rsp_rdata = r_rd_ok ? w_arr_rdata : 64'd0;

endmodule
